// File: rtl/led_matrix_scan.sv
// Row-scan driver for a ROWS x COLS RGB LED matrix: double-buffered frames,
// frame-synchronous swap, anti-ghost blanking and brightness PWM.
// Optional solid-colour test pattern when LED_TEST_PATTERN_EN is defined.
module led_matrix_scan #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int ROW_CYCLES   = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BRIGHT_BITS  = 2,
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [RW-1:0]          wr_row,
    input  logic [COLS-1:0]        wr_r,
    input  logic [COLS-1:0]        wr_g,
    input  logic [COLS-1:0]        wr_b,
    input  logic                   swap_req,
    output logic                   swap_done,
    input  logic [BRIGHT_BITS-1:0] bright,
    input  logic                   test_mode,
    output logic [COLS-1:0]        data_r,
    output logic [COLS-1:0]        data_g,
    output logic [COLS-1:0]        data_b,
    output logic [RW-1:0]          s,
    output logic                   en,
    output logic                   frame_start
);
    localparam int CW   = $clog2(ROW_CYCLES);
    localparam int DISP = ROW_CYCLES - BLANK_CYCLES;

    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [RW-1:0]     s_next;
    logic              front_reg, front_next;
    logic              pending_reg;
    logic [3*COLS-1:0] mem_reg [2][ROWS];

    logic              slot_end, frame_wrap, do_swap, wr_ok, lit;
    int                on_cycles;
    logic [3*COLS-1:0] pix;
    logic [COLS-1:0]   pix_r, pix_g, pix_b;

    assign slot_end   = (cnt_reg == CW'(ROW_CYCLES - 1));
    assign frame_wrap = slot_end && (s == RW'(ROWS - 1));
    assign do_swap    = frame_wrap && (pending_reg || swap_req);
    assign wr_ok      = wr_en && (32'(wr_row) < ROWS);
    assign on_cycles  = ((int'(bright) + 1) * DISP) >> BRIGHT_BITS;

    always_comb begin
        cnt_next   = slot_end ? '0 : cnt_reg + CW'(1);
        s_next     = s;
        if (slot_end)
            s_next = (s == RW'(ROWS - 1)) ? '0 : s + RW'(1);
        front_next = front_reg ^ do_swap;
        lit        = (int'(cnt_next) >= BLANK_CYCLES) &&
                     (int'(cnt_next) < BLANK_CYCLES + on_cycles);
    end

    // Outputs are decoded from next-state counter/row so en, s and data stay
    // aligned; a write in the swap cycle is forwarded since it lands in the new front.
    always_comb begin
        pix = mem_reg[front_next][s_next];
        if (wr_ok && ((!front_reg) == front_next) && (wr_row == s_next))
            pix = {wr_r, wr_g, wr_b};
        pix_r = pix[3*COLS-1:2*COLS];
        pix_g = pix[2*COLS-1:COLS];
        pix_b = pix[COLS-1:0];
    end

`ifdef LED_TEST_PATTERN_EN
    logic [1:0]      color_reg, color_next;
    logic            tm_d_reg;
    logic [COLS-1:0] out_r, out_g, out_b;

    always_comb begin
        color_next = color_reg;
        if (test_mode && !tm_d_reg)
            color_next = 2'd0;
        else if (frame_wrap)
            color_next = color_reg + 2'd1;
        out_r = pix_r;
        out_g = pix_g;
        out_b = pix_b;
        if (test_mode) begin
            // Sequence: red, green, blue, white.
            out_r = (color_next == 2'd0 || color_next == 2'd3) ? '1 : '0;
            out_g = (color_next == 2'd1 || color_next == 2'd3) ? '1 : '0;
            out_b = (color_next == 2'd2 || color_next == 2'd3) ? '1 : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_reg <= 2'd0;
            tm_d_reg  <= 1'b0;
        end else begin
            color_reg <= color_next;
            tm_d_reg  <= test_mode;
        end
    end
`else
    logic            unused_test_mode;
    logic [COLS-1:0] out_r, out_g, out_b;

    assign unused_test_mode = test_mode;
    assign out_r = pix_r;
    assign out_g = pix_g;
    assign out_b = pix_b;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            s           <= '0;
            front_reg   <= 1'b0;
            pending_reg <= 1'b0;
            swap_done   <= 1'b0;
            frame_start <= 1'b0;
            en          <= 1'b0;
            data_r      <= '1;
            data_g      <= '1;
            data_b      <= '1;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    mem_reg[b][r] <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            s           <= s_next;
            front_reg   <= front_next;
            pending_reg <= do_swap ? 1'b0 : (pending_reg | swap_req);
            swap_done   <= do_swap;
            frame_start <= frame_wrap;
            en          <= lit;
            data_r      <= lit ? ~out_r : '1;
            data_g      <= lit ? ~out_g : '1;
            data_b      <= lit ? ~out_b : '1;
            if (wr_ok)
                mem_reg[!front_reg][wr_row] <= {wr_r, wr_g, wr_b};
        end
    end
endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: directed scenarios plus random traffic checked
// against a cycle-index reference model (slot = k mod 16, row = k / 16 mod 8).
module tb_led_matrix_scan;
    localparam int ROWS = 8, COLS = 8, RC = 16, BL = 2, BB = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_en = 1'b0;
    logic [2:0]      wr_row = '0;
    logic [COLS-1:0] wr_r = '0, wr_g = '0, wr_b = '0;
    logic            swap_req = 1'b0;
    logic            swap_done;
    logic [BB-1:0]   bright = 2'd3;
    logic            test_mode = 1'b0;
    logic [COLS-1:0] data_r, data_g, data_b;
    logic [2:0]      s;
    logic            en;
    logic            frame_start;

    led_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .ROW_CYCLES(RC),
                      .BLANK_CYCLES(BL), .BRIGHT_BITS(BB)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .swap_req(swap_req),
        .swap_done(swap_done), .bright(bright), .test_mode(test_mode),
        .data_r(data_r), .data_g(data_g), .data_b(data_b), .s(s), .en(en),
        .frame_start(frame_start));

    always #5 clk = ~clk;

    int        vecs = 0, fails = 0;
    int        k;
    logic [23:0] mb [2][ROWS];
    int        fr, tm_frames;
    bit        pend, tm_prev, exp_sd, exp_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, expv);
        end
    endtask

    task automatic model_reset();
        k = 0; fr = 0; pend = 0; exp_sd = 0; exp_fs = 0; tm_frames = 0; tm_prev = 0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) mb[b][r] = '0;
    endtask

    task automatic check_outputs();
        int c, row, on;
        bit lit;
        logic [23:0] px;
        logic [7:0] er, eg, eb;
        c   = k % RC;
        row = (k / RC) % ROWS;
        on  = ((int'(bright) + 1) * (RC - BL)) >> BB;
        lit = (c >= BL) && (c < BL + on);
        px  = mb[fr][row];
`ifdef LED_TEST_PATTERN_EN
        if (test_mode) begin
            px[23:16] = (tm_frames % 4 == 0 || tm_frames % 4 == 3) ? 8'hFF : 8'h00;
            px[15:8]  = (tm_frames % 4 == 1 || tm_frames % 4 == 3) ? 8'hFF : 8'h00;
            px[7:0]   = (tm_frames % 4 == 2 || tm_frames % 4 == 3) ? 8'hFF : 8'h00;
        end
`endif
        er = lit ? ~px[23:16] : 8'hFF;
        eg = lit ? ~px[15:8]  : 8'hFF;
        eb = lit ? ~px[7:0]   : 8'hFF;
        chk("s", 32'(s), 32'(row));
        chk("en", 32'(en), 32'(lit));
        chk("data_r", 32'(data_r), 32'(er));
        chk("data_g", 32'(data_g), 32'(eg));
        chk("data_b", 32'(data_b), 32'(eb));
        chk("swap_done", 32'(swap_done), 32'(exp_sd));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    // One clock: advance the model with the inputs present at the edge, then check.
    task automatic tick();
        bit wrap;
        wrap = ((k % RC) == RC - 1) && (((k / RC) % ROWS) == ROWS - 1);
        @(posedge clk);
        if (wr_en && int'(wr_row) < ROWS) mb[1 - fr][wr_row] = {wr_r, wr_g, wr_b};
        exp_fs = wrap;
        exp_sd = wrap && (pend || swap_req);
        if (exp_sd) begin fr = 1 - fr; pend = 0; end
        else pend = pend | swap_req;
        if (test_mode && !tm_prev) tm_frames = 0;
        else if (wrap) tm_frames++;
        tm_prev = test_mode;
        k++;
        #1;
        check_outputs();
    endtask

    initial begin
        int n_sd, guard;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s", 32'(s), 0);
        chk("rst_en", 32'(en), 0);
        chk("rst_data", {8'h0, data_r, data_g, data_b}, 32'h00FFFFFF);
        chk("rst_pulses", {swap_done, frame_start}, 0);
        @(negedge clk); reset = 1'b0;

        // Idle scan at full brightness, two frames.
        repeat (2 * RC * ROWS) tick();

        // Write row 3 red 81, swap mid-frame.
        repeat (40) tick();
        wr_en = 1; wr_row = 3'd3; wr_r = 8'h81; wr_g = 8'h00; wr_b = 8'h00;
        tick();
        wr_en = 0; swap_req = 1;
        tick();
        swap_req = 0;
        repeat (RC * ROWS + 40) tick();

        // Dimmest and second brightness levels.
        bright = 2'd0; repeat (RC * ROWS) tick();
        bright = 2'd1; repeat (RC * ROWS) tick();
        bright = 2'd3;

        // Give the other buffer distinct content, then hold swap_req for 3 frames.
        wr_en = 1; wr_row = 3'd6; wr_r = 8'h0F; wr_g = 8'hA5; wr_b = 8'h3C;
        tick();
        wr_en = 0; swap_req = 1; n_sd = 0;
        for (int i = 0; i < 3 * RC * ROWS; i++) begin
            tick();
            if (swap_done) n_sd++;
        end
        swap_req = 0;
        chk("held_swaps", 32'(n_sd), 3);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_row   = 3'($urandom_range(0, 7));
            wr_r     = 8'($urandom); wr_g = 8'($urandom); wr_b = 8'($urandom);
            swap_req = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 40) == 0) bright = 2'($urandom);
`ifndef LED_TEST_PATTERN_EN
            if ($urandom_range(0, 30) == 0) test_mode = ~test_mode;
`endif
            tick();
        end
        wr_en = 0; swap_req = 0; test_mode = 0; bright = 2'd3;

        // Asynchronous reset while row 5 is lit.
        guard = 0;
        while (!(((k / RC) % ROWS) == 5 && (k % RC) == 7) && guard < 2000) begin
            tick(); guard++;
        end
        chk("reach_row5", 32'(guard < 2000), 1);
        reset = 1'b1;
        #1;
        chk("arst_s", 32'(s), 0);
        chk("arst_en", 32'(en), 0);
        chk("arst_data", {8'h0, data_r, data_g, data_b}, 32'h00FFFFFF);
        model_reset();
        @(negedge clk); reset = 1'b0;
        swap_req = 1; tick(); swap_req = 0;
        repeat (2 * RC * ROWS) tick();

`ifdef LED_TEST_PATTERN_EN
        // Solid-colour pattern: red, then green, blue, white on later frames.
        test_mode = 1;
        repeat (4 * RC * ROWS) tick();
        test_mode = 0; tick(); test_mode = 1;
        repeat (RC * ROWS) tick();
        test_mode = 0;
`endif
        repeat (RC) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
